// File: rtl/valid_pair_pkg.sv
// Shared types for the valid-strobe pair tracker: FSM states, pulse order codes
// and the record that is queued for each completed pair.
package valid_pair_pkg;

  localparam int REC_DATA_W     = 3;
  localparam int REC_CNT_W      = 5;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_MAX_GAP    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_V2 = 2'd1,
    WAIT_V1 = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ORD_V1   = 2'b01,
    ORD_V2   = 2'b10,
    ORD_BOTH = 2'b11
  } order_e;

  typedef struct packed {
    order_e                order;
    logic [REC_CNT_W-1:0]  gap;
    logic [REC_DATA_W-1:0] data;
    logic                  timeout;
  } pair_rec_t;

endpackage

// File: rtl/valid_pair_tracker_if.sv
// Strobe inputs and record-stream outputs of the pair tracker; the slave modport
// is the tracker's view, the master modport is the stimulus/consumer side.
interface valid_pair_tracker_if import valid_pair_pkg::*; #(
  parameter int DATA_W     = REC_DATA_W,
  parameter int CNT_W      = REC_CNT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) ();

  localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;

  logic                valid1_i;
  logic                valid2_i;
  logic [DATA_W-1:0]   data_i;
  logic                rec_valid_o;
  logic                rec_ready_i;
  logic [1:0]          rec_order_o;
  logic [CNT_W-1:0]    rec_gap_o;
  logic [DATA_W-1:0]   rec_data_o;
  logic                rec_timeout_o;
  logic                overflow_o;
  logic [CNT_BITS-1:0] fifo_count_o;

  modport slave (
    input  valid1_i, valid2_i, data_i, rec_ready_i,
    output rec_valid_o, rec_order_o, rec_gap_o, rec_data_o, rec_timeout_o,
           overflow_o, fifo_count_o
  );

  modport master (
    output valid1_i, valid2_i, data_i, rec_ready_i,
    input  rec_valid_o, rec_order_o, rec_gap_o, rec_data_o, rec_timeout_o,
           overflow_o, fifo_count_o
  );

endinterface

// File: rtl/pair_rec_fifo.sv
// Synchronous FIFO of pair records; a push into a full FIFO is accepted only when
// a pop frees the head slot in the same cycle.
module pair_rec_fifo import valid_pair_pkg::*; #(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  pair_rec_t                push_rec,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output pair_rec_t                head
);

  localparam int AW = $clog2(DEPTH);

  pair_rec_t         mem_q [DEPTH];
  pair_rec_t         mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              accept;
  logic              pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop & ~empty;
    accept   = push & (~full | pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      mem_d[wr_ptr_q] = push_rec;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({accept, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage is data only; occupancy tracking decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/valid_pair_tracker.sv
// Pairs valid1/valid2 strobes, measures order and cycle gap, and queues one record
// per pair. Define VALID_PAIR_TIMEOUT_EN to close unpartnered pairs after MAX_GAP cycles.
module valid_pair_tracker import valid_pair_pkg::*; #(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
`ifdef VALID_PAIR_TIMEOUT_EN
  , parameter int MAX_GAP  = DEF_MAX_GAP
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  valid_pair_tracker_if.slave  bus
);

  localparam int DATA_W   = REC_DATA_W;
  localparam int CNT_W    = REC_CNT_W;
  localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    gap_q, gap_d, gap_next;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic                overflow_q, overflow_d;
  logic                push, pop, full, empty;
  logic                v1, v2;
  pair_rec_t           push_rec, head;
  logic [CNT_BITS-1:0] count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] g);
    return (g == {CNT_W{1'b1}}) ? g : g + CNT_W'(1);
  endfunction

  always_comb begin
    v1       = bus.valid1_i;
    v2       = bus.valid2_i;
    gap_next = sat_inc(gap_q);
    state_d  = state_q;
    gap_d    = gap_next;
    cap_d    = cap_q;
    push     = 1'b0;
    push_rec = '{order: ORD_BOTH, gap: '0, data: bus.data_i, timeout: 1'b0};
    case (state_q)
      IDLE: begin
        gap_d = '0;
        if (v1 && v2) begin
          push = 1'b1;
        end else if (v1 || v2) begin
          cap_d   = bus.data_i;
          state_d = v1 ? WAIT_V2 : WAIT_V1;
        end
      end
      WAIT_V2, WAIT_V1: begin
        // "partner" closes the pair, "same" restarts it from the current cycle.
        if ((state_q == WAIT_V2) ? v2 : v1) begin
          push     = 1'b1;
          push_rec = '{order: (state_q == WAIT_V2) ? ORD_V1 : ORD_V2,
                       gap: gap_next, data: cap_q, timeout: 1'b0};
          if ((state_q == WAIT_V2) ? v1 : v2) begin
            cap_d = bus.data_i;
            gap_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if ((state_q == WAIT_V2) ? v1 : v2) begin
          cap_d = bus.data_i;
          gap_d = '0;
        end
`ifdef VALID_PAIR_TIMEOUT_EN
        else if (gap_next == CNT_W'(MAX_GAP)) begin
          push     = 1'b1;
          push_rec = '{order: (state_q == WAIT_V2) ? ORD_V1 : ORD_V2,
                       gap: gap_next, data: cap_q, timeout: 1'b1};
          state_d  = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    overflow_d = overflow_q | (push & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  // Gap and captured data are only meaningful in the wait states, entered from IDLE.
  always_ff @(posedge clk) begin
    gap_q <= gap_d;
    cap_q <= cap_d;
  end

  assign pop = ~empty & bus.rec_ready_i;

  pair_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_rec (push_rec),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .head     (head)
  );

  assign bus.rec_valid_o   = ~empty;
  assign bus.rec_order_o   = empty ? 2'b00 : head.order;
  assign bus.rec_gap_o     = empty ? '0 : head.gap;
  assign bus.rec_data_o    = empty ? '0 : head.data;
  assign bus.rec_timeout_o = ~empty & head.timeout;
  assign bus.overflow_o    = overflow_q;
  assign bus.fifo_count_o  = count;

endmodule

// File: tb/tb_valid_pair_tracker.sv
// Directed bench for valid_pair_tracker: a cycle-stamp pairing model with a record
// queue is compared every cycle, plus literal expectations on chosen scenarios.
module tb_valid_pair_tracker;
  import valid_pair_pkg::*;

  localparam int GAP_SAT = 31;
  localparam int DEPTH   = 4;
`ifdef VALID_PAIR_TIMEOUT_EN
  localparam int TB_MAX_GAP = 16;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  valid_pair_tracker_if bus_if ();

  valid_pair_tracker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    int order;
    int gap;
    int data;
    int tmo;
  } mrec_t;

  mrec_t q[$];
  int    cyc = 0;
  bit    pend = 0;
  int    pend_kind, pend_cyc, pend_data;
  bit    m_ovf = 0;
  bit    chk_en = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: remember the cycle of the first pulse; the gap is a cycle difference.
  always @(posedge clk) begin
    bit    v1, v2, have_new, popm, partner, same;
    int    sz0;
    mrec_t r;
    v1       = bus_if.valid1_i;
    v2       = bus_if.valid2_i;
    have_new = 0;
    r        = '{0, 0, 0, 0};
    if (!rst_n) begin
      q.delete();
      pend  = 0;
      m_ovf = 0;
    end else begin
      if (!pend) begin
        if (v1 && v2) begin
          r = '{3, 0, int'(bus_if.data_i), 0};
          have_new = 1;
        end else if (v1 || v2) begin
          pend      = 1;
          pend_kind = v1 ? 1 : 2;
          pend_cyc  = cyc;
          pend_data = int'(bus_if.data_i);
        end
      end else begin
        partner = (pend_kind == 1) ? v2 : v1;
        same    = (pend_kind == 1) ? v1 : v2;
        if (partner) begin
          r = '{pend_kind, ((cyc - pend_cyc) > GAP_SAT) ? GAP_SAT : (cyc - pend_cyc), pend_data, 0};
          have_new = 1;
          if (same) begin
            pend_cyc  = cyc;
            pend_data = int'(bus_if.data_i);
          end else begin
            pend = 0;
          end
        end else if (same) begin
          pend_cyc  = cyc;
          pend_data = int'(bus_if.data_i);
        end
`ifdef VALID_PAIR_TIMEOUT_EN
        else if ((cyc - pend_cyc) == TB_MAX_GAP) begin
          r = '{pend_kind, TB_MAX_GAP, pend_data, 1};
          have_new = 1;
          pend = 0;
        end
`endif
      end
      sz0  = q.size();
      popm = (sz0 > 0) && bus_if.rec_ready_i;
      if (popm) void'(q.pop_front());
      if (have_new) begin
        if (sz0 == DEPTH && !popm) m_ovf = 1;
        else q.push_back(r);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit    ev;
      mrec_t h;
      ev = (q.size() > 0);
      h  = ev ? q[0] : '{0, 0, 0, 0};
      check("rec_valid",   int'(bus_if.rec_valid_o),   int'(ev));
      check("rec_order",   int'(bus_if.rec_order_o),   h.order);
      check("rec_gap",     int'(bus_if.rec_gap_o),     h.gap);
      check("rec_data",    int'(bus_if.rec_data_o),    h.data);
      check("rec_timeout", int'(bus_if.rec_timeout_o), h.tmo);
      check("overflow",    int'(bus_if.overflow_o),    int'(m_ovf));
      check("fifo_count",  int'(bus_if.fifo_count_o),  q.size());
    end
  end

  task automatic step(input bit a, input bit b, input int d);
    bus_if.valid1_i = a;
    bus_if.valid2_i = b;
    bus_if.data_i   = d[2:0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 7);
  endtask

  task automatic head_is(input string tag, input int o, input int g, input int d, input int t);
    check({tag, "_valid"},   int'(bus_if.rec_valid_o),   1);
    check({tag, "_order"},   int'(bus_if.rec_order_o),   o);
    check({tag, "_gap"},     int'(bus_if.rec_gap_o),     g);
    check({tag, "_data"},    int'(bus_if.rec_data_o),    d);
    check({tag, "_timeout"}, int'(bus_if.rec_timeout_o), t);
  endtask

  initial begin
    bus_if.valid1_i    = 1'b0;
    bus_if.valid2_i    = 1'b0;
    bus_if.data_i      = '0;
    bus_if.rec_ready_i = 1'b1;
    rst_n = 1'b0;
    idle(2);
    chk_en = 1;
    check("rst_valid", int'(bus_if.rec_valid_o), 0);
    check("rst_count", int'(bus_if.fifo_count_o), 0);
    check("rst_ovf",   int'(bus_if.overflow_o), 0);
    rst_n = 1'b1;
    idle(2);

    // v1 then v2 four cycles later
    step(1, 0, 5); idle(3); step(0, 1, 1);
    head_is("basic", 1, 4, 5, 0);

    step(1, 1, 2);
    head_is("simul", 3, 0, 2, 0);

    step(0, 1, 6); step(1, 0, 3);
    head_is("v2first", 2, 1, 6, 0);

    // second v1 restarts the pair
    step(1, 0, 1); idle(2); step(1, 0, 4); idle(3); step(0, 1, 0);
    head_is("restart", 1, 4, 4, 0);

    // v1&v2 while waiting for v2: close and reopen
    step(1, 0, 3); step(1, 1, 5);
    head_is("reopen1", 1, 1, 3, 0);
    step(0, 1, 0);
    head_is("reopen2", 1, 1, 5, 0);
    idle(1);

    // overflow with consumer stalled
    bus_if.rec_ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) step(1, 1, k);
    check("ovf_count", int'(bus_if.fifo_count_o), 4);
    check("ovf_flag",  int'(bus_if.overflow_o), 1);
    check("ovf_head",  int'(bus_if.rec_data_o), 1);
    bus_if.rec_ready_i = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      idle(1);
      check("drain_data", int'(bus_if.rec_data_o), k);
    end
    idle(1);
    check("drain_empty", int'(bus_if.rec_valid_o), 0);

    // full FIFO with simultaneous pop accepts the push
    bus_if.rec_ready_i = 1'b0;
    for (int k = 7; k >= 4; k--) step(1, 1, k);
    bus_if.rec_ready_i = 1'b1;
    step(1, 1, 3);
    check("fullpop_count", int'(bus_if.fifo_count_o), 4);
    check("fullpop_head",  int'(bus_if.rec_data_o), 6);
    idle(4);
    check("fullpop_drained", int'(bus_if.fifo_count_o), 0);

    // lone v1: timeout or indefinite wait with saturated gap
    step(1, 0, 6);
`ifdef VALID_PAIR_TIMEOUT_EN
    idle(15);
    check("to_before", int'(bus_if.fifo_count_o), 0);
    idle(1);
    head_is("timeout", 1, 16, 6, 1);
    idle(3);
    step(0, 1, 0);
    idle(3);
    check("to_after_v2", int'(bus_if.fifo_count_o), 0);
    idle(20);
`else
    idle(40);
    check("nto_count", int'(bus_if.fifo_count_o), 0);
    step(0, 1, 0);
    head_is("saturate", 1, 31, 6, 0);
    idle(1);
`endif

    // reset mid-pair
    step(1, 0, 2); idle(1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("midrst_valid", int'(bus_if.rec_valid_o), 0);
    check("midrst_count", int'(bus_if.fifo_count_o), 0);
    check("midrst_ovf",   int'(bus_if.overflow_o), 0);
    step(0, 1, 3); idle(3);
    check("lone_v2_valid", int'(bus_if.rec_valid_o), 0);
    check("lone_v2_count", int'(bus_if.fifo_count_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
